// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit unit: control-store bit
// positions, store size encodings and the store-sequencing FSM states.
package wb_pkg;

    localparam int CSW_DEF = 53;
    localparam int PAW_DEF = 15;

    localparam int CS_REG1_WE  = 0;
    localparam int CS_REG2_WE  = 1;
    localparam int CS_SEG_WE   = 2;
    localparam int CS_FLAGS_WE = 3;
    localparam int CS_DF_WE    = 4;
    localparam int CS_MEM1_WE  = 5;
    localparam int CS_MEM2_WE  = 6;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_DWORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1A,
        ST_S1B,
        ST_S2A,
        ST_S2B
    } state_t;

endpackage

// File: rtl/wb_store_align.sv
// Forms one word-sized store beat (word address, lane-aligned data, byte
// enables) from a byte address and size. The high beat carries whatever
// bytes did not fit in the low word, starting at lane 0.
module wb_store_align
    import wb_pkg::*;
#(
    parameter int PAW = PAW_DEF
) (
    input  logic [PAW-1:0] pa_lo,
    input  logic [PAW-1:0] pa_hi,
    input  logic [1:0]     size,
    input  logic [31:0]    data,
    input  logic           spill,
    input  logic           high,
    output logic [PAW-3:0] addr,
    output logic [31:0]    wdata,
    output logic [3:0]     be
);

    logic [2:0] n;
    logic [2:0] k;
    logic [2:0] o;
    logic       unused_ok;

    // k is the number of bytes landing in the low word; the offset always
    // comes from the low address, even when forming the high beat.
    always_comb begin
        case (size)
            SZ_BYTE:  n = 3'd1;
            SZ_WORD:  n = 3'd2;
            SZ_DWORD: n = 3'd4;
            default:  n = 3'd4;
        endcase
        o = {1'b0, pa_lo[1:0]};
        k = spill ? (3'd4 - o) : n;
        if (high) begin
            addr  = pa_hi[PAW-1:2];
            wdata = data >> {k, 3'b000};
            be    = 4'((5'd1 << (n - k)) - 5'd1);
        end else begin
            addr  = pa_lo[PAW-1:2];
            wdata = data << {o, 3'b000};
            be    = 4'(((8'd1 << k) - 8'd1) << o);
        end
    end

    assign unused_ok = ^pa_hi[1:0];

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: retires register/flag/EIP updates in one cycle and
// sequences up to four store beats, stalling the WB latch until the last
// beat is accepted.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no beat in flight; first beat of a new entry is offered now
// S1A   | store1 low beat (waiting for acceptance)
// S1B   | store1 high beat (spilled store1)
// S2A   | store2 low beat
// S2B   | store2 high beat (spilled store2)
module wb_commit
    import wb_pkg::*;
#(
    parameter int CSW = CSW_DEF,
    parameter int PAW = PAW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CSW-1:0] cs,
    input  logic [31:0]    data1,
    input  logic [31:0]    data2,
    input  logic [31:0]    eip,
    input  logic [31:0]    neip,
    input  logic [PAW-1:0] pa1,
    input  logic [PAW-1:0] pa2,
    input  logic [PAW-1:0] pa3,
    input  logic [PAW-1:0] pa4,
    input  logic [1:0]     size1,
    input  logic [1:0]     size2,
    input  logic [5:0]     eflags,
    input  logic [1:0]     op_size,
    input  logic [2:0]     dr1,
    input  logic [2:0]     dr2,
    input  logic [2:0]     dr_seg,
    input  logic [1:0]     spill,
    input  logic           dflag,
    input  logic           v,
    input  logic           mem_ready,
    output logic           stall,
    output logic           retire,
    output logic           gpr_we1,
    output logic           gpr_we2,
    output logic [2:0]     gpr_dr1,
    output logic [2:0]     gpr_dr2,
    output logic [31:0]    gpr_data1,
    output logic [31:0]    gpr_data2,
    output logic [1:0]     gpr_size,
    output logic           seg_we,
    output logic [2:0]     seg_dr,
    output logic [15:0]    seg_data,
    output logic           flags_we,
    output logic [5:0]     flags_out,
    output logic           df,
    output logic           eip_we,
    output logic [31:0]    eip_out,
    output logic           mem_valid,
    output logic [PAW-3:0] mem_addr,
    output logic [31:0]    mem_data,
    output logic [3:0]     mem_be
);

    state_t state, state_nxt, cur, succ;
    logic   mem1, mem2, accept, done;
    logic   second, high, b_spill;
    logic   [PAW-1:0] b_pa_lo, b_pa_hi;
    logic   [1:0]     b_size;
    logic   [31:0]    b_data;
    logic   unused_ok;

    // State register; reset aborts any partially sent instruction.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Beat selection, successor, handshake, stall/retire and next state.
    // From IDLE the first beat is offered combinationally so a single-beat
    // store completes in one cycle.
    always_comb begin
        mem1 = v & cs[CS_MEM1_WE];
        mem2 = v & cs[CS_MEM2_WE];

        cur = state;
        if (state == ST_IDLE)
            cur = mem1 ? ST_S1A : (mem2 ? ST_S2A : ST_IDLE);

        succ = ST_IDLE;
        case (cur)
            ST_S1A:  succ = spill[0] ? ST_S1B : (mem2 ? ST_S2A : ST_IDLE);
            ST_S1B:  succ = mem2 ? ST_S2A : ST_IDLE;
            ST_S2A:  succ = spill[1] ? ST_S2B : ST_IDLE;
            default: succ = ST_IDLE;
        endcase

        mem_valid = v & ~rst & (cur != ST_IDLE);
        accept    = mem_valid & mem_ready;
        done      = accept & (succ == ST_IDLE);
        stall     = mem_valid & ~done;
        retire    = v & ~rst & ((cur == ST_IDLE) | done);

        state_nxt = cur;
        if (!v || cur == ST_IDLE) state_nxt = ST_IDLE;
        else if (accept)          state_nxt = succ;
    end

    // Operand mux for the shared beat formatter.
    always_comb begin
        second  = (cur == ST_S2A) || (cur == ST_S2B);
        high    = (cur == ST_S1B) || (cur == ST_S2B);
        b_pa_lo = second ? pa3 : pa1;
        b_pa_hi = second ? pa4 : pa2;
        b_size  = second ? size2 : size1;
        b_data  = second ? data2 : data1;
        b_spill = second ? spill[1] : spill[0];
    end

    wb_store_align #(.PAW(PAW)) u_align (
        .pa_lo (b_pa_lo),
        .pa_hi (b_pa_hi),
        .size  (b_size),
        .data  (b_data),
        .spill (b_spill),
        .high  (high),
        .addr  (mem_addr),
        .wdata (mem_data),
        .be    (mem_be)
    );

    // DF is the only architectural state held locally.
    always_ff @(posedge clk) begin
        if (rst)                        df <= 1'b0;
        else if (retire & cs[CS_DF_WE]) df <= dflag;
    end

    assign gpr_we1   = retire & cs[CS_REG1_WE];
    assign gpr_we2   = retire & cs[CS_REG2_WE];
    assign seg_we    = retire & cs[CS_SEG_WE];
    assign flags_we  = retire & cs[CS_FLAGS_WE];
    assign eip_we    = retire;
    assign gpr_dr1   = dr1;
    assign gpr_dr2   = dr2;
    assign gpr_data1 = data1;
    assign gpr_data2 = data2;
    assign gpr_size  = op_size;
    assign seg_dr    = dr_seg;
    assign seg_data  = data1[15:0];
    assign flags_out = eflags;
    assign eip_out   = neip;

    assign unused_ok = ^{eip, cs};

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed cases plus randomized instructions checked
// against a byte-lane model of each store.
module tb_wb_commit;
    import wb_pkg::*;

    typedef struct packed {
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [52:0] cs;
    logic [31:0] data1, data2, eip, neip;
    logic [14:0] pa1, pa2, pa3, pa4;
    logic [1:0]  size1, size2, op_size, spill;
    logic [5:0]  eflags;
    logic [2:0]  dr1, dr2, dr_seg;
    logic        dflag, v, mem_ready;

    logic        stall, retire, gpr_we1, gpr_we2, seg_we, flags_we, df, eip_we, mem_valid;
    logic [2:0]  gpr_dr1, gpr_dr2, seg_dr;
    logic [31:0] gpr_data1, gpr_data2, eip_out, mem_data;
    logic [1:0]  gpr_size;
    logic [15:0] seg_data;
    logic [5:0]  flags_out;
    logic [12:0] mem_addr;
    logic [3:0]  mem_be;

    int    n_assert = 0;
    int    n_fail   = 0;
    logic  df_m     = 1'b0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    wb_commit dut (
        .clk(clk), .rst(rst), .cs(cs), .data1(data1), .data2(data2), .eip(eip), .neip(neip),
        .pa1(pa1), .pa2(pa2), .pa3(pa3), .pa4(pa4), .size1(size1), .size2(size2),
        .eflags(eflags), .op_size(op_size), .dr1(dr1), .dr2(dr2), .dr_seg(dr_seg),
        .spill(spill), .dflag(dflag), .v(v), .mem_ready(mem_ready),
        .stall(stall), .retire(retire), .gpr_we1(gpr_we1), .gpr_we2(gpr_we2),
        .gpr_dr1(gpr_dr1), .gpr_dr2(gpr_dr2), .gpr_data1(gpr_data1), .gpr_data2(gpr_data2),
        .gpr_size(gpr_size), .seg_we(seg_we), .seg_dr(seg_dr), .seg_data(seg_data),
        .flags_we(flags_we), .flags_out(flags_out), .df(df), .eip_we(eip_we),
        .eip_out(eip_out), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_be(mem_be)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Byte j of the store goes to byte address plo+j; bytes past the low
    // word land in the following word starting at lane 0.
    task automatic add_store(input logic [14:0] plo, input logic [14:0] phi,
                             input logic [1:0] sz, input logic [31:0] d);
        int    n = 1 << sz;
        int    o = int'(plo[1:0]);
        beat_t lo, hi;
        bit    has_hi = 0;
        lo.addr = plo[14:2]; lo.be = '0; lo.data = '0;
        hi.addr = phi[14:2]; hi.be = '0; hi.data = '0;
        for (int j = 0; j < n; j++) begin
            int ba = o + j;
            if (ba < 4) begin
                lo.be[ba] = 1'b1;
                lo.data[8*ba +: 8] = d[8*j +: 8];
            end else begin
                hi.be[ba-4] = 1'b1;
                hi.data[8*(ba-4) +: 8] = d[8*j +: 8];
                has_hi = 1;
            end
        end
        exp_q.push_back(lo);
        if (has_hi) exp_q.push_back(hi);
    endtask

    task automatic clear_inputs();
        cs = '0; data1 = '0; data2 = '0; eip = '0; neip = '0;
        pa1 = '0; pa2 = '0; pa3 = '0; pa4 = '0; size1 = '0; size2 = '0;
        eflags = '0; op_size = '0; dr1 = '0; dr2 = '0; dr_seg = '0;
        spill = '0; dflag = 1'b0; v = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic build_model();
        exp_q.delete();
        if (cs[CS_MEM1_WE]) add_store(pa1, pa2, size1, data1);
        if (cs[CS_MEM2_WE]) add_store(pa3, pa4, size2, data2);
    endtask

    task automatic rand_store(output logic [14:0] plo, output logic [14:0] phi,
                              output logic [1:0] sz, output logic sp);
        logic [12:0] w;
        logic [1:0]  o;
        sz  = 2'($urandom_range(0, 2));
        o   = 2'($urandom_range(0, 3));
        w   = 13'($urandom);
        plo = {w, o};
        phi = {w + 13'd1, 2'b00};
        sp  = (int'(o) + (1 << sz)) > 4;
    endtask

    task automatic rand_instr();
        logic sp1, sp2;
        cs = {21'($urandom), $urandom};
        data1 = $urandom; data2 = $urandom; eip = $urandom; neip = $urandom;
        eflags = 6'($urandom); op_size = 2'($urandom_range(0, 2));
        dr1 = 3'($urandom); dr2 = 3'($urandom); dr_seg = 3'($urandom);
        dflag = 1'($urandom);
        rand_store(pa1, pa2, size1, sp1);
        rand_store(pa3, pa4, size2, sp2);
        spill = {sp2, sp1};
        v = 1'b1;
        build_model();
    endtask

    function automatic int pick_wait(input int mode);
        if (mode == 0) return 0;
        if (mode == 2) return 2;
        return int'($urandom_range(0, 2));
    endfunction

    // Present the current latch contents until the model says it retires.
    // Called and returns at posedge+1.
    task automatic run_instr(input int mode);
        int    nb = exp_q.size();
        int    idx = 0, wcnt = 0, cyc = 0;
        int    w = pick_wait(mode);
        bit    done = 0, last, exp_ret;
        beat_t b;
        while (!done && cyc < 60) begin
            mem_ready = (nb == 0) ? 1'($urandom_range(0, 1)) : (wcnt >= w);
            @(negedge clk);
            check("mem_valid", mem_valid, nb > 0);
            if (nb > 0) begin
                b = exp_q[idx];
                check("mem_addr", mem_addr, b.addr);
                check("mem_be", mem_be, b.be);
                check("mem_data", mem_data & lane_mask(b.be), b.data);
            end
            last    = (nb > 0) && mem_ready && (idx == nb - 1);
            exp_ret = (nb == 0) || last;
            check("stall", stall, (nb > 0) && !last);
            check("retire", retire, exp_ret);
            check("eip_we", eip_we, exp_ret);
            check("gpr_we1", gpr_we1, exp_ret & cs[CS_REG1_WE]);
            check("gpr_we2", gpr_we2, exp_ret & cs[CS_REG2_WE]);
            check("seg_we", seg_we, exp_ret & cs[CS_SEG_WE]);
            check("flags_we", flags_we, exp_ret & cs[CS_FLAGS_WE]);
            if (exp_ret) begin
                check("eip_out", eip_out, neip);
                check("gpr_data1", gpr_data1, data1);
                check("gpr_data2", gpr_data2, data2);
                check("gpr_dr", {gpr_dr1, gpr_dr2, seg_dr, gpr_size},
                      {dr1, dr2, dr_seg, op_size});
                check("seg_data", seg_data, data1[15:0]);
                check("flags_out", flags_out, eflags);
            end
            @(posedge clk); #1;
            cyc++;
            if (exp_ret) begin
                if (cs[CS_DF_WE]) df_m = dflag;
                done = 1;
            end else if (nb > 0 && mem_ready) begin
                idx++; wcnt = 0; w = pick_wait(mode);
            end else begin
                wcnt++;
            end
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL timeout: retire not reached after %0d cycles", cyc);
        end
        check("df", df, df_m);
    endtask

    initial begin
        clear_inputs();
        // Reset with a fully enabled store entry present: everything quiet.
        rst = 1'b1; v = 1'b1; cs = '1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_gpr_we1", gpr_we1, 1'b0);
        check("rst_eip_we", eip_we, 1'b0);
        check("rst_df", df, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();

        // Invalid entry: no enables, no request, no stall.
        cs = '1; mem_ready = 1'b1;
        @(negedge clk);
        check("inv_mem_valid", mem_valid, 1'b0);
        check("inv_stall", stall, 1'b0);
        check("inv_retire", retire, 1'b0);
        check("inv_seg_we", seg_we, 1'b0);
        @(posedge clk); #1;

        // Register-only retire in the presenting cycle; also sets DF.
        clear_inputs();
        v = 1'b1; cs[CS_REG1_WE] = 1'b1; cs[CS_DF_WE] = 1'b1; dflag = 1'b1;
        dr1 = 3'd3; data1 = 32'hDEADBEEF; op_size = 2'd2; neip = 32'h0000_1234;
        build_model();
        run_instr(0);

        // Aligned dword store, single beat.
        clear_inputs();
        v = 1'b1; cs[CS_MEM1_WE] = 1'b1; size1 = SZ_DWORD;
        pa1 = 15'h0100; pa2 = 15'h0104; data1 = 32'h11223344;
        build_model();
        run_instr(0);

        // Spilled dword store: two beats, stall on the first only.
        clear_inputs();
        v = 1'b1; cs[CS_MEM1_WE] = 1'b1; size1 = SZ_DWORD; spill = 2'b01;
        pa1 = 15'h0103; pa2 = 15'h0104; data1 = 32'hAABBCCDD;
        build_model();
        check("spill_beat0_data", exp_q[0].data, 32'hDD000000);
        check("spill_beat1_data", exp_q[1].data, 32'h00AABBCC);
        run_instr(0);

        // Two spilled stores, each beat held 2 cycles before acceptance.
        clear_inputs();
        v = 1'b1; cs[CS_MEM1_WE] = 1'b1; cs[CS_MEM2_WE] = 1'b1; cs[CS_FLAGS_WE] = 1'b1;
        size1 = SZ_DWORD; size2 = SZ_DWORD; spill = 2'b11; eflags = 6'h2A;
        pa1 = 15'h0103; pa2 = 15'h0104; pa3 = 15'h0202; pa4 = 15'h0204;
        data1 = 32'hAABBCCDD; data2 = 32'h55667788;
        build_model();
        run_instr(2);

        // Reset during S1B: aborted instruction never retires, DF clears.
        clear_inputs();
        v = 1'b1; cs[CS_MEM1_WE] = 1'b1; cs[CS_MEM2_WE] = 1'b1; cs[CS_DF_WE] = 1'b1;
        size1 = SZ_DWORD; size2 = SZ_WORD; spill = 2'b01; dflag = 1'b1;
        pa1 = 15'h0301; pa2 = 15'h0304; pa3 = 15'h0400; pa4 = 15'h0404;
        data1 = 32'h01020304; data2 = 32'h0000BEEF;
        build_model();
        mem_ready = 1'b1;
        @(negedge clk);
        check("abort_s1a_addr", mem_addr, exp_q[0].addr);
        check("abort_s1a_stall", stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("abort_rst_mem_valid", mem_valid, 1'b0);
        check("abort_rst_retire", retire, 1'b0);
        check("abort_rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; v = 1'b0; df_m = 1'b0;
        @(negedge clk);
        check("abort_post_mem_valid", mem_valid, 1'b0);
        check("abort_post_retire", retire, 1'b0);
        check("abort_post_df", df, 1'b0);
        @(posedge clk); #1;

        // Randomized back-to-back instructions with random acceptance delay.
        for (int t = 0; t < 60; t++) begin
            rand_instr();
            run_instr((t % 4 == 0) ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
